// File: rtl/rv_pkg.sv
// Shared RV32I decode types: opcodes, immediate formats
// and the ID/EX pipeline register bundle.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_val;
        logic [XLEN-1:0]       rs2_val;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic                  funct7b5;
        logic                  is_load;
        logic                  illegal;
    } id_ex_t;

endpackage

// File: rtl/decode_issue_stage_if.sv
// IF/ID input handshake and ID/EX register outputs of the
// decode stage; master is the fetch/execute side, slave is decode.
interface decode_issue_stage_if;
    import rv_pkg::*;

    logic                  in_valid;
    logic [XLEN-1:0]       in_instr;
    logic [XLEN-1:0]       in_pc;
    logic                  in_ready;

    logic                  ex_valid;
    logic [XLEN-1:0]       ex_pc;
    logic [XLEN-1:0]       ex_rs1_val;
    logic [XLEN-1:0]       ex_rs2_val;
    logic [XLEN-1:0]       ex_imm;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [6:0]            ex_opcode;
    logic [2:0]            ex_funct3;
    logic                  ex_funct7b5;
    logic                  ex_is_load;
    logic                  ex_illegal;

    modport master (
        output in_valid, in_instr, in_pc,
        input  in_ready,
        input  ex_valid, ex_pc, ex_rs1_val, ex_rs2_val,
        input  ex_imm, ex_rd, ex_rs1, ex_rs2,
        input  ex_opcode, ex_funct3, ex_funct7b5,
        input  ex_is_load, ex_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc,
        output in_ready,
        output ex_valid, ex_pc, ex_rs1_val, ex_rs2_val,
        output ex_imm, ex_rd, ex_rs1, ex_rs2,
        output ex_opcode, ex_funct3, ex_funct7b5,
        output ex_is_load, ex_illegal
    );

endinterface

// File: rtl/imm_gen.sv
// RV32I immediate generator: sign-extends from instr[31];
// the opcode bits are not needed, so only [31:7] comes in.
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:7]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        unique case (imm_type)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25],
                          instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31],
                          instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode stage: register read with WB bypass, load-use stall,
// immediate generation and the ID/EX pipeline register.
module decode_issue_stage
    import rv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    decode_issue_stage_if.slave   bus,
    output logic [REG_ADDR_W-1:0] rf_a_addr,
    output logic [REG_ADDR_W-1:0] rf_b_addr,
    input  logic [XLEN-1:0]       rf_a_data,
    input  logic [XLEN-1:0]       rf_b_data,
    input  logic                  wb_write,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    input  logic                  hold
);

    logic [6:0]            opc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;

    imm_type_e             imm_type;
    logic [XLEN-1:0]       imm;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  has_rd;
    logic                  is_load;
    logic                  illegal;

    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic                  hazard;
    logic                  ready;

    id_ex_t                dec;
    id_ex_t                q;
    id_ex_t                q_next;

    assign opc = bus.in_instr[6:0];
    assign rd  = bus.in_instr[11:7];
    assign rs1 = bus.in_instr[19:15];
    assign rs2 = bus.in_instr[24:20];

    assign rf_a_addr = rs1;
    assign rf_b_addr = rs2;

    always_comb begin
        imm_type = IMM_NONE;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        has_rd   = 1'b1;
        is_load  = 1'b0;
        illegal  = 1'b0;
        unique case (opc)
            OPC_LUI, OPC_AUIPC: begin
                imm_type = IMM_U;
                uses_rs1 = 1'b0;
            end
            OPC_JAL: begin
                imm_type = IMM_J;
                uses_rs1 = 1'b0;
            end
            OPC_JALR:  imm_type = IMM_I;
            OPC_BRANCH: begin
                imm_type = IMM_B;
                uses_rs2 = 1'b1;
                has_rd   = 1'b0;
            end
            OPC_LOAD: begin
                imm_type = IMM_I;
                is_load  = 1'b1;
            end
            OPC_STORE: begin
                imm_type = IMM_S;
                uses_rs2 = 1'b1;
                has_rd   = 1'b0;
            end
            OPC_OPIMM: imm_type = IMM_I;
            OPC_OP:    uses_rs2 = 1'b1;
            default: begin
                illegal = 1'b1;
                has_rd  = 1'b0;
            end
        endcase
    end

    imm_gen u_imm_gen (
        .instr    (bus.in_instr[31:7]),
        .imm_type (imm_type),
        .imm      (imm)
    );

    // The RF writes at the edge, so a same-cycle read is stale.
    always_comb begin
        rs1_val = rf_a_data;
        rs2_val = rf_b_data;
        if (wb_write && wb_addr != '0 && wb_addr == rs1)
            rs1_val = wb_data;
        if (wb_write && wb_addr != '0 && wb_addr == rs2)
            rs2_val = wb_data;
    end

    assign hazard = bus.in_valid && q.valid && q.is_load
                 && q.rd != '0
                 && ((uses_rs1 && q.rd == rs1)
                  || (uses_rs2 && q.rd == rs2));

    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = bus.in_pc;
        dec.rs1_val  = rs1_val;
        dec.rs2_val  = rs2_val;
        dec.imm      = imm;
        dec.rd       = has_rd ? rd : '0;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.opcode   = opc;
        dec.funct3   = bus.in_instr[14:12];
        dec.funct7b5 = bus.in_instr[30];
        dec.is_load  = is_load;
        dec.illegal  = illegal;
    end

    always_comb begin
        q_next = q;
        ready  = 1'b1;
        if (reset) begin
            ready = 1'b0;
        end else if (flush) begin
            q_next = '0;
        end else if (hold) begin
            ready = 1'b0;
        end else if (hazard) begin
            q_next = '0;
            ready  = 1'b0;
        end else begin
            q_next = bus.in_valid ? dec : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= q_next;
    end

    assign bus.in_ready    = ready;
    assign bus.ex_valid    = q.valid;
    assign bus.ex_pc       = q.pc;
    assign bus.ex_rs1_val  = q.rs1_val;
    assign bus.ex_rs2_val  = q.rs2_val;
    assign bus.ex_imm      = q.imm;
    assign bus.ex_rd       = q.rd;
    assign bus.ex_rs1      = q.rs1;
    assign bus.ex_rs2      = q.rs2;
    assign bus.ex_opcode   = q.opcode;
    assign bus.ex_funct3   = q.funct3;
    assign bus.ex_funct7b5 = q.funct7b5;
    assign bus.ex_is_load  = q.is_load;
    assign bus.ex_illegal  = q.illegal;

endmodule
